// File: rtl/chaos_pkg.sv
// chaos_pkg: fp32 field constants and flag bit positions for the chaos key extractor
package chaos_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int EXP_BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
  localparam int FLAG_ERR = 0;
  localparam int FLAG_OVF = 1;
endpackage

// File: rtl/chaos_key_extractor_fp32_to_fixed.sv
// fp32_to_fixed: two-stage fp32 magnitude to INT_W.FRAC_W fixed conversion with stall enable
module fp32_to_fixed
  import chaos_pkg::*;
#(
  parameter int INT_W = 32,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [31:0]             x,
  output logic [INT_W+FRAC_W-1:0] fixed,
  output logic                    err,
  output logic                    ovf
);
  localparam int W = INT_W + FRAC_W;
  logic [30:0] mag;
  logic [EXP_W-1:0] ex;
  logic [MAN_W:0] mant, mant_q;
  logic signed [9:0] e, e_q, s;
  logic err_q, ovf_q;
  logic [W-1:0] fixed_d;
  assign mag = 31'(x & 32'h7FFF_FFFF);
  assign ex = mag[MAN_W +: EXP_W];
  always_comb begin
    mant = {ex != '0, mag[MAN_W-1:0]};
    e = (ex == '0) ? 10'(1 - EXP_BIAS) : 10'(ex) - 10'(EXP_BIAS);
    s = e_q + 10'(FRAC_W - MAN_W);
    fixed_d = s[9] ? W'(mant_q) >> (-s) : W'(mant_q) << s;
  end
  always_ff @(posedge clk)
    if (en) begin
      mant_q <= mant;
      e_q <= e;
      err_q <= ex == EXP_SPECIAL;
      ovf_q <= ex != EXP_SPECIAL && e >= 10'(INT_W);
      fixed <= (err_q | ovf_q) ? '0 : fixed_d;
      err <= err_q;
      ovf <= ovf_q;
    end
endmodule

// File: rtl/chaos_key_extractor.sv
// chaos_key_extractor: 4-stage pipeline turning fp32 chaotic samples into key digits floor(|x|*SCALE) mod MOD
module chaos_key_extractor
  import chaos_pkg::*;
#(
  parameter int NCH = 3,
  parameter int INT_W = 32,
  parameter int FRAC_W = 23,
  parameter int SCALE = 1000000,
  parameter int SCALE_W = 20,
  parameter int MOD = 1000,
  parameter int KEY_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*32-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*KEY_W-1:0] out_key,
  output logic [NCH*2-1:0]     out_flag
);
  localparam int W = INT_W + FRAC_W;
  localparam int PW = W + SCALE_W;
  localparam int QW = PW - FRAC_W;
  logic adv;
  logic [2:0] v;
  logic [NCH*KEY_W-1:0] key_d;
  logic [NCH*2-1:0] flag_d;
  assign adv = !out_valid | out_ready;
  assign in_ready = adv;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [W-1:0] fixed;
    logic err, ovf, err_q, ovf_q;
    logic [QW-1:0] q;
    fp32_to_fixed #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_cvt (
      .clk(clk),
      .en(adv),
      .x(in_data[32*c +: 32]),
      .fixed(fixed),
      .err(err),
      .ovf(ovf)
    );
    always_ff @(posedge clk)
      if (adv) begin
        q <= QW'((PW'(fixed) * PW'(SCALE)) >> FRAC_W);
        err_q <= err;
        ovf_q <= ovf;
      end
    assign key_d[KEY_W*c +: KEY_W] = KEY_W'(q % QW'(MOD));
    assign flag_d[2*c+FLAG_ERR] = err_q;
    assign flag_d[2*c+FLAG_OVF] = ovf_q;
  end
  // only valid beats update the output registers so bubbles never expose stale data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v <= '0;
      out_valid <= 1'b0;
      out_key <= '0;
      out_flag <= '0;
    end else if (adv) begin
      v <= {v[1:0], in_valid};
      out_valid <= v[2];
      if (v[2]) begin
        out_key <= key_d;
        out_flag <= flag_d;
      end
    end
endmodule

// File: tb/tb_chaos_key_extractor.sv
// tb_chaos_key_extractor: directed and randomized checks against a real-arithmetic reference model
module tb_chaos_key_extractor;
  localparam int NCH = 3;
  localparam int KEY_W = 23;
  localparam int MOD = 1000;
  typedef struct packed {
    logic [NCH*2-1:0] flag;
    logic [NCH*KEY_W-1:0] key;
  } beat_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [NCH*32-1:0] in_data = '0;
  logic [NCH*KEY_W-1:0] out_key;
  logic [NCH*2-1:0] out_flag;
  int errors = 0, checks = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  chaos_key_extractor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key), .out_flag(out_flag)
  );

  // returns {ovf, err, key} from the numeric value of x
  function automatic logic [KEY_W+1:0] ref_ch(input logic [31:0] x);
    int ex, e;
    longint mant, fixed;
    real r;
    logic [127:0] p;
    ex = int'(x[30:23]);
    if (ex == 255) return {2'b01, {KEY_W{1'b0}}};
    e = (ex == 0) ? -126 : ex - 127;
    if (e >= 32) return {2'b10, {KEY_W{1'b0}}};
    mant = longint'(x[22:0]);
    if (ex != 0) mant += 8388608;
    r = real'(mant) * 2.0 ** (e - 23);
    fixed = longint'($floor(r * 8388608.0));
    p = 128'(fixed) * 128'(1000000);
    return {2'b00, KEY_W'((p >> 23) % 128'(MOD))};
  endfunction

  function automatic beat_t ref_beat(input logic [NCH*32-1:0] d);
    beat_t b;
    logic [KEY_W+1:0] r;
    for (int c = 0; c < NCH; c++) begin
      r = ref_ch(d[32*c +: 32]);
      b.key[KEY_W*c +: KEY_W] = r[KEY_W-1:0];
      b.flag[2*c +: 2] = r[KEY_W+1:KEY_W];
    end
    return b;
  endfunction

  function automatic logic [NCH*32-1:0] rand_beat();
    logic [NCH*32-1:0] d;
    logic [31:0] x;
    int k;
    for (int c = 0; c < NCH; c++) begin
      x = $urandom;
      k = $urandom_range(0, 15);
      x[30:23] = (k == 0) ? 8'd255 : (k == 1) ? 8'd0 :
                 (k == 2) ? 8'($urandom_range(159, 254)) : 8'($urandom_range(100, 158));
      d[32*c +: 32] = x;
    end
    return d;
  endfunction

  task automatic send_wait(input logic [NCH*32-1:0] d, output int n);
    in_data = d;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) in_valid = 1'b0;
    end while (!out_valid && n < 20);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (out_key !== '0) begin errors++; $display("FAIL reset_out_key got=%h want=0", out_key); end
    if (out_flag !== '0) begin errors++; $display("FAIL reset_out_flag got=%b want=0", out_flag); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int n;
    send_wait({32'h0, 32'h0, 32'h4519DC72}, n);
    checks += 4;
    if (n != 4) begin errors++; $display("FAIL t1_latency got=%0d want=4", n); end
    if (out_key[KEY_W-1:0] !== 23'd832) begin errors++; $display("FAIL t1_key got=%0d want=832", out_key[KEY_W-1:0]); end
    if (out_flag !== '0) begin errors++; $display("FAIL t1_flag got=%b want=0", out_flag); end
    @(posedge clk); #1;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_dup got=%b want=0", out_valid); end
  endtask

  task automatic test_values();
    int n;
    send_wait({32'h00000001, 32'h3F800000, 32'h3DCCCCCD}, n);
    checks += 3;
    if (n != 4) begin errors++; $display("FAIL t2_latency got=%0d want=4", n); end
    if (out_key !== {23'd0, 23'd0, 23'd999}) begin errors++; $display("FAIL t2_key got=%h want=%h", out_key, {23'd0, 23'd0, 23'd999}); end
    if (out_flag !== 6'b0) begin errors++; $display("FAIL t2_flag got=%b want=000000", out_flag); end
    @(posedge clk); #1;
    send_wait({32'hC519DC72, 32'h501502F9, 32'h7FC00000}, n);
    checks += 3;
    if (n != 4) begin errors++; $display("FAIL t3_latency got=%0d want=4", n); end
    if (out_key !== {23'd832, 23'd0, 23'd0}) begin errors++; $display("FAIL t3_key got=%h want=%h", out_key, {23'd832, 23'd0, 23'd0}); end
    if (out_flag !== 6'b00_10_01) begin errors++; $display("FAIL t3_flag got=%b want=001001", out_flag); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [NCH*32-1:0] beats[8];
    logic [NCH*KEY_W-1:0] held;
    beat_t b;
    int idx = 0, got = 0, cyc = 0;
    for (int i = 0; i < 8; i++) beats[i] = rand_beat();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = beats[idx];
      #1;
      if (in_valid && in_ready) begin exp_q.push_back(ref_beat(in_data)); idx++; end
      @(posedge clk); #1;
      if (i == 5) held = out_key;
    end
    checks += 4;
    if (idx != 4) begin errors++; $display("FAIL t4_accepts got=%0d want=4", idx); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL t4_in_ready got=%b want=0", in_ready); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL t4_out_valid got=%b want=1", out_valid); end
    if (out_key !== held) begin errors++; $display("FAIL t4_stable got=%h want=%h", out_key, held); end
    out_ready = 1'b1;
    while (got < 8 && cyc < 100) begin
      in_valid = idx < 8;
      in_data = beats[idx < 8 ? idx : 7];
      #1;
      if (out_valid && out_ready) begin
        checks++;
        got++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL t4_extra got=%h want=none", out_key); end
        else begin
          b = exp_q.pop_front();
          if ({out_flag, out_key} !== b) begin errors++; $display("FAIL t4_beat got=%h want=%h", {out_flag, out_key}, b); end
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(ref_beat(in_data)); idx++; end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 8) begin errors++; $display("FAIL t4_count got=%0d want=8", got); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL t4_dup got=%b want=0", out_valid); end
  endtask

  task automatic test_random(input int n);
    beat_t b;
    int sent = 0, got = 0, cyc = 0;
    while (got < n && cyc < 20000) begin
      in_valid = (sent < n) && ($urandom % 2 == 1);
      in_data = rand_beat();
      out_ready = ($urandom % 2 == 1);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        got++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL t5_extra got=%h want=none", out_key); end
        else begin
          b = exp_q.pop_front();
          if ({out_flag, out_key} !== b) begin errors++; $display("FAIL t5_beat got=%h want=%h in_order=%0d", {out_flag, out_key}, b, got); end
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(ref_beat(in_data)); sent++; end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks += 2;
    if (got != n) begin errors++; $display("FAIL t5_count got=%0d want=%0d", got, n); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL t5_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = rand_beat();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL t6_rst_out_valid got=%b want=0", out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL t6_stale got=%0d want=0", seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_values();
    test_backpressure();
    test_random(1000);
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
